// File: rtl/sqb_pkg.sv
// rtl/sqb_pkg.sv - shared types and helpers for the stack/queue buffer
package sqb_pkg;

    // Ordering discipline of the buffer.
    typedef enum logic {
        MODE_LIFO = 1'b0,
        MODE_FIFO = 1'b1
    } sqb_mode_e;

    // Number of storage entries for a given pointer width.
    function automatic int sqb_depth(input int address_depth);
        return 1 << address_depth;
    endfunction

endpackage

// File: rtl/sqb_ram.sv
// rtl/sqb_ram.sv - storage array: one synchronous write port, one asynchronous read port
//
// Ports:
//   clk    write clock
//   we     write enable, samples waddr/wdata on the rising edge
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  combinational read data at raddr
module sqb_ram
    import sqb_pkg::*;
#(
    parameter int AddrWidth = 4,
    parameter int DataWidth = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [AddrWidth-1:0] raddr,
    output logic [DataWidth-1:0] rdata
);

    localparam int Depth = sqb_depth(AddrWidth);

    // Contents are deliberately left unreset so this maps onto plain RAM.
    logic [DataWidth-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_queue_buffer.sv
// rtl/stack_queue_buffer.sv - runtime-selectable LIFO/FIFO buffer with occupancy and sticky error flags
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   CS         chip enable; when low every input is ignored and all state holds
//   Mode       0 = LIFO, 1 = FIFO; only takes effect while the buffer is empty
//   Push       store Data_In this edge
//   Pop        read one entry into Data_Out this edge
//   ClrErr     clear Overflow/Underflow
//   Data_In    write data
//   Data_Out   registered read data
//   Count      number of stored entries, 0..2**AddressDepth
//   Full       Count equals capacity
//   Empty      Count is zero
//   Overflow   sticky: a push was rejected while Full
//   Underflow  sticky: a pop was rejected while Empty
module stack_queue_buffer
    import sqb_pkg::*;
#(
    parameter int AddressDepth = 4,
    parameter int DataWide     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CS,
    input  logic                  Mode,
    input  logic                  Push,
    input  logic                  Pop,
    input  logic                  ClrErr,
    input  logic [DataWide-1:0]   Data_In,
    output logic [DataWide-1:0]   Data_Out,
    output logic [AddressDepth:0] Count,
    output logic                  Full,
    output logic                  Empty,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam int                    Depth     = sqb_depth(AddressDepth);
    localparam logic [AddressDepth:0] FullCount = (AddressDepth + 1)'(Depth);
    localparam logic [AddressDepth:0] CountOne  = (AddressDepth + 1)'(1);
    localparam logic [AddressDepth-1:0] PtrOne  = AddressDepth'(1);

    logic [AddressDepth-1:0] wr_ptr;
    logic [AddressDepth-1:0] rd_ptr;
    sqb_mode_e               active_mode;
    sqb_mode_e               eff_mode;

    logic                    both_req;
    logic                    fifo_loaded;
    logic                    pass_through;
    logic                    swap;
    logic                    push_ok;
    logic                    pop_ok;
    logic                    ovf_evt;
    logic                    unf_evt;
    logic                    ram_we;
    logic [AddressDepth-1:0] ram_raddr;
    logic [DataWide-1:0]     ram_rdata;

    assign Full  = (Count == FullCount);
    assign Empty = (Count == '0);

    // The mode input is only honoured when nothing is stored, so the ordering
    // of resident data can never change underneath the consumer.
    assign eff_mode = Empty ? sqb_mode_e'(Mode) : active_mode;

    always_comb begin
        both_req     = Push && Pop;
        fifo_loaded  = (eff_mode == MODE_FIFO) && !Empty;
        // A simultaneous push+pop either forwards the input straight through
        // (stack, or empty queue) or rotates the queue by one entry.
        pass_through = both_req && !fifo_loaded;
        swap         = both_req && fifo_loaded;
        push_ok      = Push && !Pop && !Full;
        pop_ok       = Pop && !Push && !Empty;
        ovf_evt      = Push && !Pop && Full;
        unf_evt      = Pop && !Push && Empty;
        ram_we       = CS && (push_ok || swap);
        // Stack reads the top-of-stack just below wr_ptr; queue reads the head.
        ram_raddr    = (eff_mode == MODE_LIFO) ? (wr_ptr - PtrOne) : rd_ptr;
    end

    sqb_ram #(
        .AddrWidth (AddressDepth),
        .DataWidth (DataWide)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (Data_In),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Data_Out    <= '0;
            Count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            active_mode <= MODE_LIFO;
            Overflow    <= 1'b0;
            Underflow   <= 1'b0;
        end else if (CS) begin
            active_mode <= eff_mode;

            if (swap) begin
                Data_Out <= ram_rdata;
                rd_ptr   <= rd_ptr + PtrOne;
                wr_ptr   <= wr_ptr + PtrOne;
            end else if (pass_through) begin
                Data_Out <= Data_In;
            end else if (push_ok) begin
                wr_ptr <= wr_ptr + PtrOne;
                Count  <= Count + CountOne;
            end else if (pop_ok) begin
                Data_Out <= ram_rdata;
                Count    <= Count - CountOne;
                if (eff_mode == MODE_LIFO) begin
                    wr_ptr <= wr_ptr - PtrOne;
                end else begin
                    rd_ptr <= rd_ptr + PtrOne;
                end
            end

            // Stack operation never moves rd_ptr, so realign the queue head to
            // the write position whenever empty; a later switch to queue mode
            // then starts from the first entry written.
            if (Empty) begin
                rd_ptr <= wr_ptr;
            end

            // A fresh error in the same cycle as ClrErr keeps the flag set.
            Overflow  <= ovf_evt || (Overflow && !ClrErr);
            Underflow <= unf_evt || (Underflow && !ClrErr);
        end
    end

endmodule

// File: tb/tb_stack_queue_buffer.sv
// tb/tb_stack_queue_buffer.sv - self-checking bench for stack_queue_buffer
module tb_stack_queue_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       CS;
    logic       Mode;
    logic       Push;
    logic       Pop;
    logic       ClrErr;
    logic [7:0] Data_In;
    logic [7:0] Data_Out;
    logic [4:0] Count;
    logic       Full;
    logic       Empty;
    logic       Overflow;
    logic       Underflow;

    int checks = 0;
    int errors = 0;

    stack_queue_buffer #(
        .AddressDepth (4),
        .DataWide     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .CS        (CS),
        .Mode      (Mode),
        .Push      (Push),
        .Pop       (Pop),
        .ClrErr    (ClrErr),
        .Data_In   (Data_In),
        .Data_Out  (Data_Out),
        .Count     (Count),
        .Full      (Full),
        .Empty     (Empty),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: stored data kept as an ordered list, oldest first.
    logic [7:0] m_q[$];
    bit         m_mode;
    logic [7:0] m_dout;
    bit         m_ovf;
    bit         m_unf;
    bit         cmp_en = 1'b0;
    bit         mode_in = 1'b0;

    function automatic void chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_mode = 1'b0;
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endfunction

    function automatic void model_step(input bit cs, input bit md, input bit push,
                                       input bit pop, input bit clr, input logic [7:0] din);
        bit eff;
        bit ov;
        bit un;
        if (!cs) return;
        eff    = (m_q.size() == 0) ? md : m_mode;
        m_mode = eff;
        ov = 1'b0;
        un = 1'b0;
        if (push && pop) begin
            if (!eff || m_q.size() == 0) begin
                m_dout = din;
            end else begin
                m_dout = m_q.pop_front();
                m_q.push_back(din);
            end
        end else if (push) begin
            if (m_q.size() == 16) ov = 1'b1;
            else m_q.push_back(din);
        end else if (pop) begin
            if (m_q.size() == 0) un = 1'b1;
            else m_dout = eff ? m_q.pop_front() : m_q.pop_back();
        end
        m_ovf = ov || (m_ovf && !clr);
        m_unf = un || (m_unf && !clr);
    endfunction

    // Every falling edge: all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("data_out",  int'(Data_Out),  int'(m_dout));
            chk("count",     int'(Count),     m_q.size());
            chk("full",      int'(Full),      int'(m_q.size() == 16));
            chk("empty",     int'(Empty),     int'(m_q.size() == 0));
            chk("overflow",  int'(Overflow),  int'(m_ovf));
            chk("underflow", int'(Underflow), int'(m_unf));
        end
    end

    task automatic step(input bit cs, input bit push, input bit pop, input bit clr,
                        input logic [7:0] din);
        CS      = cs;
        Mode    = mode_in;
        Push    = push;
        Pop     = pop;
        ClrErr  = clr;
        Data_In = din;
        @(posedge clk);
        model_step(cs, mode_in, push, pop, clr, din);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        CS = 1'b0; Mode = 1'b0; Push = 1'b0; Pop = 1'b0; ClrErr = 1'b0; Data_In = 8'h00;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cmp_en = 1'b1;
        #1;

        // 1 Reset in the middle of a cycle clears outputs immediately.
        mode_in = 1'b0;
        step(1, 1, 0, 0, 8'h11);
        step(1, 1, 0, 0, 8'h22);
        step(1, 1, 0, 0, 8'h33);
        step(1, 0, 1, 0, 8'h00);
        chk("pre_reset_dout", int'(Data_Out), 8'h33);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_count", int'(Count), 0);
        chk("rst_empty", int'(Empty), 1);
        chk("rst_dout",  int'(Data_Out), 0);
        chk("rst_flags", int'({Overflow, Underflow}), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // 2 Stack: fill, overflow, drain in reverse.
        for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 8'(i));
        chk("lifo_full",  int'(Full), 1);
        chk("lifo_count", int'(Count), 16);
        step(1, 1, 0, 0, 8'h10);
        chk("lifo_ovf",       int'(Overflow), 1);
        chk("lifo_ovf_count", int'(Count), 16);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 1, 0, 8'h00);
            chk("lifo_pop", int'(Data_Out), 15 - i);
        end
        chk("lifo_empty", int'(Empty), 1);
        step(1, 0, 0, 1, 8'h00);

        // 3 Queue: arrival order, then a rotating window with pointer wrap.
        mode_in = 1'b1;
        for (int i = 1; i <= 5; i++) step(1, 1, 0, 0, 8'(i));
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 1, 0, 8'h00);
            chk("fifo_pop", int'(Data_Out), i);
        end
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 8'h40 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 1, 0, 8'h80 + 8'(i));
            chk("fifo_pair", int'(Data_Out), (i < 8) ? (8'h40 + i) : (8'h80 + i - 8));
            chk("fifo_pair_count", int'(Count), 8);
        end
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 8'h00);
        chk("fifo_last", int'(Data_Out), 8'h93);

        // 4 Errors.
        step(1, 0, 1, 0, 8'h00);
        chk("unf_set",  int'(Underflow), 1);
        chk("unf_hold", int'(Data_Out), 8'h93);
        step(1, 0, 0, 1, 8'h00);
        chk("unf_clr", int'(Underflow), 0);
        step(1, 0, 1, 1, 8'h00);
        chk("unf_wins", int'(Underflow), 1);
        step(1, 0, 0, 1, 8'h00);

        // 5 Simultaneous push+pop.
        mode_in = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 8'h21 + 8'(i));
        step(1, 1, 1, 0, 8'hAA);
        chk("lifo_pp_dout",  int'(Data_Out), 8'hAA);
        chk("lifo_pp_count", int'(Count), 3);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 8'h00);
        chk("lifo_pp_top", int'(Data_Out), 8'h21);
        mode_in = 1'b1;
        for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 8'hC0 + 8'(i));
        step(1, 1, 1, 0, 8'hBB);
        chk("fifo_pp_dout",  int'(Data_Out), 8'hC0);
        chk("fifo_pp_count", int'(Count), 16);
        chk("fifo_pp_ovf",   int'(Overflow), 0);
        for (int i = 0; i < 16; i++) step(1, 0, 1, 0, 8'h00);
        chk("fifo_pp_last", int'(Data_Out), 8'hBB);

        // 6 Gating: mode change while loaded, then chip select low.
        mode_in = 1'b0;
        step(1, 1, 0, 0, 8'h51);
        step(1, 1, 0, 0, 8'h52);
        mode_in = 1'b1;
        step(1, 0, 1, 0, 8'h00);
        chk("mode_lock0", int'(Data_Out), 8'h52);
        step(1, 0, 1, 0, 8'h00);
        chk("mode_lock1", int'(Data_Out), 8'h51);
        mode_in = 1'b0;
        step(1, 0, 1, 0, 8'h00);
        step(1, 1, 0, 0, 8'h61);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 8'hEE);
        step(0, 1, 0, 1, 8'hEE);
        chk("cs_count", int'(Count), 1);
        chk("cs_unf",   int'(Underflow), 1);
        chk("cs_dout",  int'(Data_Out), 8'h51);

        // 7 Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            mode_in = ($urandom_range(0, 9) == 0) ? ~mode_in : mode_in;
            step(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, 8'($urandom));
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
